// File: rtl/br_lite_ni.sv
// BrLite local-port network interface: TX flit injector, RX receive FIFO.
package BrLitePkg;

  localparam int unsigned BR_ADDR_W    = 16;
  localparam int unsigned BR_PAYLOAD_W = 16;
  localparam int unsigned BR_ID_W      = 4;

  typedef enum logic [1:0] {
    BR_SVC_CLEAR = 2'd0,
    BR_SVC_ALL   = 2'd1,
    BR_SVC_TGT   = 2'd2
  } br_svc_t;

  typedef struct packed {
    logic [BR_ADDR_W-1:0]    source;
    logic [BR_ADDR_W-1:0]    target;
    br_svc_t                 service;
    logic [BR_PAYLOAD_W-1:0] payload;
    logic [BR_ID_W-1:0]      id;
  } br_data_t;

endpackage

module br_lite_ni
  import BrLitePkg::*;
#(
  parameter logic [15:0] ADDRESS  = 16'h0000,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  input  br_svc_t                       tx_service_i,
  input  logic [15:0]                   tx_target_i,
  input  logic [BR_PAYLOAD_W-1:0]       tx_payload_i,
  output logic                          tx_err_o,
  output br_data_t                      br_flit_o,
  output logic                          br_req_o,
  input  logic                          br_ack_i,
  input  logic                          br_busy_i,
  input  br_data_t                      br_flit_i,
  input  logic                          br_req_i,
  output logic                          br_ack_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output br_data_t                      rx_flit_o,
  output logic [$clog2(RX_DEPTH):0]     rx_count_o,
  output logic                          irq_o
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_RELEASE
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_t;

  tx_state_t            tx_state, tx_state_nxt;
  rx_state_t            rx_state, rx_state_nxt;
  logic [BR_ID_W-1:0]   id_cnt;
  logic                 tx_accept;
  logic                 tx_legal;

  br_data_t             mem [RX_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;
  logic                 fifo_full;
  logic                 push, pop;

  // ---------------- TX path ----------------
  assign tx_legal  = (tx_service_i == BR_SVC_ALL) || (tx_service_i == BR_SVC_TGT);
  assign tx_accept = tx_valid_i && tx_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tx_state <= TX_IDLE;
    else         tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:    if (tx_accept && tx_legal) tx_state_nxt = TX_REQ;
      TX_REQ:     if (br_ack_i)              tx_state_nxt = TX_RELEASE;
      TX_RELEASE: if (!br_ack_i)             tx_state_nxt = TX_IDLE;
      default:                               tx_state_nxt = TX_IDLE;
    endcase
  end

  // Ready is gated by rst_ni so it reads low for the whole reset window.
  always_comb begin
    tx_ready_o = rst_ni && (tx_state == TX_IDLE) && !br_busy_i;
    br_req_o   = (tx_state == TX_REQ);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_flit_o <= '0;
      id_cnt    <= '0;
      tx_err_o  <= 1'b0;
    end else begin
      tx_err_o <= tx_accept && !tx_legal;
      if (tx_accept && tx_legal) begin
        br_flit_o.source  <= ADDRESS;
        br_flit_o.target  <= tx_target_i;
        br_flit_o.service <= tx_service_i;
        br_flit_o.payload <= tx_payload_i;
        br_flit_o.id      <= id_cnt;
        id_cnt            <= id_cnt + BR_ID_W'(1);
      end
    end
  end

  // ---------------- RX path ----------------
  assign fifo_full = (count == CW'(RX_DEPTH));
  assign push      = (rx_state == RX_IDLE) && br_req_i && !fifo_full;
  assign pop       = (count != '0) && rx_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_state <= RX_IDLE;
    else         rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE: if (push)      rx_state_nxt = RX_ACK;
      RX_ACK:  if (!br_req_i) rx_state_nxt = RX_IDLE;
      default:                rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    br_ack_o = (rx_state == RX_ACK);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= br_flit_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rx_count_o = count;
  assign rx_valid_o = (count != '0);
  assign rx_flit_o  = mem[rptr];
  assign irq_o      = rx_valid_o;

endmodule
